// File: rtl/fir_dac_serialiser_if.sv
// Stream-in / serial-DAC-out bundle for fir_dac_serialiser.
// The master side is the FIR plus control logic; the slave side is the serialiser.
interface fir_dac_serialiser_if #(
    parameter int IN_W  = 16,
    parameter int DEPTH = 4
);
    // Filtered sample stream and control
    logic signed [IN_W-1:0]    out;
    logic                      output_ready;
    logic                      clr_ovf;

    // DAC serial link and status
    logic                      sync_n;
    logic                      sclk;
    logic                      sdata;
    logic                      busy;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic                      overflow;

    modport master (
        output out, output_ready, clr_ovf,
        input  sync_n, sclk, sdata, busy, fifo_level, overflow
    );

    modport slave (
        input  out, output_ready, clr_ovf,
        output sync_n, sclk, sdata, busy, fifo_level, overflow
    );
endinterface

// File: rtl/fir_dac_serialiser.sv
// FIR-to-DAC serialiser: buffers signed samples in a small FIFO, rounds and
// saturates them to an offset-binary DAC word, and shifts the word out MSB
// first on a 3-wire link (sync_n / sclk / sdata). Each bit takes two clocks,
// and a one-cycle gap separates consecutive frames.
module fir_dac_serialiser #(
    parameter int DEPTH = 4,
    parameter int IN_W  = 16,
    parameter int DAC_W = 12
) (
    input  logic                 ck,
    input  logic                 rst_n,
    fir_dac_serialiser_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (DAC_W > 1) ? $clog2(DAC_W) : 1;

    // Half an LSB of the DAC word, expressed at the input scale.
    localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (IN_W - DAC_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Round to nearest, clamp the one positive overflow case, then flip the
    // sign bit so the most negative input maps to code 0.
    function automatic logic [DAC_W-1:0] to_offset_binary(input logic signed [IN_W-1:0] s);
        logic [IN_W:0]    r;
        logic [DAC_W-1:0] w;
        r = {s[IN_W-1], s} + RND;
        if (!r[IN_W] && r[IN_W-1]) begin
            w = {1'b0, {(DAC_W-1){1'b1}}};
        end else begin
            w = DAC_W'(r >> (IN_W - DAC_W));
        end
        return {~w[DAC_W-1], w[DAC_W-2:0]};
    endfunction

    state_t            state_r, state_nx;
    logic [IN_W-1:0]   mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [DAC_W-1:0]  shreg_r;
    logic [BW-1:0]     bit_cnt_r;
    logic              phase_r;
    logic              sync_n_r, sclk_r, sdata_r, busy_r, ovf_r;

    logic              empty_s, full_s;
    logic              push_s, pop_s, drop_s;
    logic              load_s, phase_up_s, bit_step_s, frame_end_s;
    logic [DAC_W-1:0]  head_code_s;

    assign empty_s     = (level_r == {LW{1'b0}});
    assign full_s      = (level_r == LW'(DEPTH));
    assign head_code_s = to_offset_binary(mem_r[rd_ptr_r]);

    // Next-state logic and per-cycle datapath strobes for the frame FSM.
    always_comb begin
        state_nx    = state_r;
        load_s      = 1'b0;
        phase_up_s  = 1'b0;
        bit_step_s  = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (!empty_s) begin
                    load_s   = 1'b1;
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!phase_r) begin
                    phase_up_s = 1'b1;
                end else if (bit_cnt_r == {BW{1'b0}}) begin
                    frame_end_s = 1'b1;
                    state_nx    = ST_GAP;
                end else begin
                    bit_step_s = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FIFO push/pop/drop decisions; a full FIFO still accepts when it pops on the same edge.
    always_comb begin
        pop_s  = load_s;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (bus.output_ready) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ck) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.out;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Shift register and registered serial outputs; sdata only moves when sclk falls.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= {DAC_W{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            phase_r   <= 1'b0;
            sync_n_r  <= 1'b1;
            sclk_r    <= 1'b0;
            sdata_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            busy_r <= (state_nx != ST_IDLE);
            if (load_s) begin
                shreg_r   <= head_code_s;
                bit_cnt_r <= BW'(DAC_W - 1);
                phase_r   <= 1'b0;
                sync_n_r  <= 1'b0;
                sclk_r    <= 1'b0;
                sdata_r   <= head_code_s[DAC_W-1];
            end else if (phase_up_s) begin
                phase_r <= 1'b1;
                sclk_r  <= 1'b1;
            end else if (bit_step_s) begin
                phase_r   <= 1'b0;
                sclk_r    <= 1'b0;
                bit_cnt_r <= bit_cnt_r - BW'(1);
                shreg_r   <= shreg_r << 1;
                sdata_r   <= shreg_r[DAC_W-2];
            end else if (frame_end_s) begin
                phase_r  <= 1'b0;
                sync_n_r <= 1'b1;
                sclk_r   <= 1'b0;
                sdata_r  <= 1'b0;
            end
        end
    end

    assign bus.sync_n     = sync_n_r;
    assign bus.sclk       = sclk_r;
    assign bus.sdata      = sdata_r;
    assign bus.busy       = busy_r;
    assign bus.fifo_level = level_r;
    assign bus.overflow   = ovf_r;

endmodule

// File: doc/fir_dac_serialiser.md
Name: fir_dac_serialiser

Overview:
- Downstream of the FIR filter: consumes the 16-bit signed filtered stream (out/output_ready) and drives a 3-wire serial 12-bit DAC (sync_n, sclk, sdata).
- Converts each sample to 12-bit offset binary with rounding and saturation.
- Buffers samples in a small FIFO and serialises them MSB first.
- Sized for a 1 MHz ck with a 40 kHz sample rate: frame pitch is 25 cycles.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- IN_W, 16, input sample width (signed two's complement).
- DAC_W, 12, DAC word width; must be less than IN_W.

Ports:
- ck  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- out  input  IN_W  signed filtered sample from the FIR.
- output_ready  input  1  one-cycle strobe; out is valid in that cycle.
- clr_ovf  input  1  synchronous clear of overflow.
- sync_n  output  1  frame select, low for the duration of a word.
- sclk  output  1  serial clock; DAC samples sdata on the rising edge.
- sdata  output  1  serial data, MSB first.
- busy  output  1  high while a frame is in progress (SHIFT or GAP).
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): sync_n=1, sclk=0, sdata=0, busy=0, fifo_level=0, overflow=0, FSM=IDLE, FIFO emptied. Reset mid-frame aborts the word; sync_n rises immediately.
- Capture: on an edge with output_ready=1, push out into the FIFO.
  - FIFO full and no pop on the same edge: drop the sample and set overflow.
  - FIFO full with a pop on the same edge: accept the push.
  - No bypass path: a push into an empty FIFO is popped on the next edge.
- Conversion at pop, done combinationally on the FIFO head:
  - r = out + 2^(IN_W-DAC_W-1), computed at IN_W+1 bits.
  - If r exceeds the maximum positive value, saturate to 0x7FF.
  - Otherwise take r[IN_W-1 : IN_W-DAC_W].
  - Invert the MSB to form offset binary: 0x000 is the most negative code, 0x800 is zero.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if FIFO is non-empty, at the edge: pop, load shreg, bit_cnt=DAC_W-1, phase=0, sync_n=0, sclk=0, sdata=converted MSB; go to SHIFT.
  - SHIFT: each bit takes 2 cycles. phase 0 drives sclk=0; phase 1 drives sclk=1. sdata changes only on the phase 1→0 transition.
  - After phase 1 of bit 0: sync_n=1, sclk=0, sdata=0; go to GAP.
  - Frame length is 2*DAC_W cycles with sync_n low (24 at default).
  - GAP lasts exactly 1 cycle. At its end, if FIFO is non-empty, start the next frame exactly as from IDLE; otherwise go to IDLE. Minimum frame pitch is 2*DAC_W+1 = 25 cycles.
- busy=1 in SHIFT and GAP.
- Latency: sample pushed at edge k → sync_n falls after edge k+1 when the FSM was IDLE.
- overflow: set on a drop; cleared by clr_ovf. If a drop and clr_ovf occur on the same edge, set wins.
- fifo_level: reflects the push/pop result after each edge and never exceeds DEPTH.
- output_ready and out are ignored during reset.

Test Plan:
- Single sample out=16'sh1234 → r=0x123C, word=0x123 → offset binary 0x923. Bits 1001_0010_0011 sampled on 12 sclk rising edges; sync_n low 24 cycles, starting after edge k+1.
- out=-10000 (0xD8F0) → 0x58F; out=+10000 (0x2710) → 0xA71. Square-wave input alternating these two values must reproduce both words exactly.
- Saturation and extremes:
  - out=16'sh7FFC → rounding overflows → 0xFFF.
  - out=16'sh8000 → 0x000.
  - out=0 → 0x800.
  - out=16'sh0007 → 0x800.
  - out=16'sh0008 → 0x801.
- Overflow with DEPTH=4: output_ready high for 6 consecutive cycles with values 1..6.
  - Samples 1–5 are transmitted in order.
  - Sample 6 is dropped; overflow=1 after the 6th edge; fifo_level peaks at 4.
  - clr_ovf pulse → overflow=0.
- Sustained stream: output_ready pulsed every 25 cycles for 100 samples.
  - overflow stays 0; fifo_level ≤ 1.
  - Every sample is serialised; sync_n is high for ≥1 cycle between frames.
- Reset mid-frame: assert rst_n low during bit 5 with 2 samples queued.
  - Outputs go to reset values without waiting for ck; fifo_level=0.
  - After release, a new sample 16'sh1234 produces a clean 0x923 frame.
